// File: rtl/mux_8to1_rr_if.sv
// mux_8to1_rr_if: eight valid/ready input streams and one tagged output stream.
interface mux_8to1_rr_if #(parameter int WIDTH = 8);
    logic [7:0]         in_valid;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_last;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_last;
    logic               out_ready;
    modport slave (input in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_data, out_sel, out_last);
    modport master (output in_valid, in_data, in_last, out_ready,
                    input in_ready, out_valid, out_data, out_sel, out_last);
endinterface

// File: rtl/mux_8to1_rr.sv
// mux_8to1_rr: round-robin 8-to-1 stream mux with packet locking and a registered output.
module mux_8to1_rr #(parameter int WIDTH = 8) (
    input logic         clk,
    input logic         rst_n,
    mux_8to1_rr_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d, lock_q, lock_d, sel_q, sel_d, ch;
    logic             valid_q, valid_d, last_q, last_d, any_v, load_en, acc;
    logic [WIDTH-1:0] data_q, data_d;
    // Lowest offset from ptr wins; a locked packet ignores every other channel.
    always_comb begin
        ch = ptr_q;
        any_v = 1'b0;
        if (state_q == LOCKED) begin
            ch = lock_q;
            any_v = bus.in_valid[lock_q];
        end else begin
            for (int k = 7; k >= 0; k--) begin
                if (bus.in_valid[ptr_q + 3'(k)]) begin
                    ch = ptr_q + 3'(k);
                    any_v = 1'b1;
                end
            end
        end
    end
    assign load_en = !valid_q || bus.out_ready;
    assign acc = load_en && any_v;
    assign bus.in_ready = (acc && rst_n) ? 8'b1 << ch : 8'b0;
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        lock_d = lock_q;
        valid_d = valid_q;
        data_d = data_q;
        sel_d = sel_q;
        last_d = last_q;
        if (acc) begin
            valid_d = 1'b1;
            data_d = bus.in_data[ch*WIDTH +: WIDTH];
            sel_d = ch;
            last_d = bus.in_last[ch];
            state_d = bus.in_last[ch] ? IDLE : LOCKED;
            ptr_d = bus.in_last[ch] ? ch + 3'd1 : ptr_q;
            lock_d = ch;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            lock_q <= '0;
            valid_q <= 1'b0;
            data_q <= '0;
            sel_q <= '0;
            last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            lock_q <= lock_d;
            valid_q <= valid_d;
            data_q <= data_d;
            sel_q <= sel_d;
            last_q <= last_d;
        end
    end
    assign bus.out_valid = valid_q;
    assign bus.out_data = data_q;
    assign bus.out_sel = sel_q;
    assign bus.out_last = last_q;
endmodule

// File: tb/tb_mux_8to1_rr.sv
// tb_mux_8to1_rr: directed scenarios with hand-computed expectations for mux_8to1_rr.
module tb_mux_8to1_rr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    mux_8to1_rr_if #(.WIDTH(8)) bus ();
    mux_8to1_rr #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 8'h00;
        bus.in_last = 8'hFF;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid = 8'hFF;
        bus.in_last = 8'hFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = 8'h10 + 8'(i);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_sel} !== 12'h000) begin
            failures++;
            $display("FAIL reset_hold in_ready/valid/sel=%h/%b/%0d expected 00/0/0", bus.in_ready, bus.out_valid, bus.out_sel);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 8'h01) begin
            failures++;
            $display("FAIL reset_first_grant in_ready=%h expected 01", bus.in_ready);
        end
    endtask

    task automatic test_fairness();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 3'(n % 8), 8'h10 + 8'(n % 8), 1'b1}) begin
                failures++;
                $display("FAIL fairness_beat%0d got v=%b sel=%0d data=%h expected sel=%0d data=%h", n, bus.out_valid, bus.out_sel, bus.out_data, n % 8, 8'h10 + 8'(n % 8));
            end
        end
        bus.in_valid = 8'h00;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fairness_drain out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_packet_lock();
        do_reset();
        bus.in_valid = 8'h24;
        bus.in_last = 8'hFB;
        bus.in_data[2*8 +: 8] = 8'hA0;
        bus.in_data[5*8 +: 8] = 8'h55;
        #1;
        checks++;
        if (bus.in_ready !== 8'h04) begin
            failures++;
            $display("FAIL lock_first_grant in_ready=%h expected 04", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 3'd2, 8'hA0, 1'b0}) begin
            failures++;
            $display("FAIL lock_beat0 sel=%0d data=%h last=%b expected 2/a0/0", bus.out_sel, bus.out_data, bus.out_last);
        end
        bus.in_valid = 8'h20;
        #1;
        checks++;
        if (bus.in_ready !== 8'h00) begin
            failures++;
            $display("FAIL lock_bubble_ready in_ready=%h expected 00", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lock_bubble_out out_valid=%b expected 0", bus.out_valid);
        end
        bus.in_valid = 8'h24;
        bus.in_data[2*8 +: 8] = 8'hA1;
        #1;
        checks++;
        if (bus.in_ready !== 8'h04) begin
            failures++;
            $display("FAIL lock_resume_ready in_ready=%h expected 04", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 3'd2, 8'hA1, 1'b0}) begin
            failures++;
            $display("FAIL lock_beat1 sel=%0d data=%h last=%b expected 2/a1/0", bus.out_sel, bus.out_data, bus.out_last);
        end
        bus.in_data[2*8 +: 8] = 8'hA2;
        bus.in_last = 8'hFF;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 3'd2, 8'hA2, 1'b1}) begin
            failures++;
            $display("FAIL lock_beat2 sel=%0d data=%h last=%b expected 2/a2/1", bus.out_sel, bus.out_data, bus.out_last);
        end
        bus.in_valid = 8'h20;
        #1;
        checks++;
        if (bus.in_ready !== 8'h20) begin
            failures++;
            $display("FAIL lock_release_ready in_ready=%h expected 20", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 3'd5, 8'h55, 1'b1}) begin
            failures++;
            $display("FAIL lock_next_ch sel=%0d data=%h expected 5/55", bus.out_sel, bus.out_data);
        end
        bus.in_valid = 8'h00;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.in_valid = 8'h09;
        bus.in_last = 8'hFF;
        bus.in_data[0 +: 8] = 8'hC0;
        bus.in_data[3*8 +: 8] = 8'hC3;
        @(negedge clk);
        bus.in_valid = 8'h08;
        bus.out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready} !== {1'b1, 3'd0, 8'hC0, 8'h00}) begin
                failures++;
                $display("FAIL bp_hold%0d v=%b sel=%0d data=%h in_ready=%h expected 1/0/c0/00", n, bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 8'h08) begin
            failures++;
            $display("FAIL bp_release_ready in_ready=%h expected 08", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd3, 8'hC3}) begin
            failures++;
            $display("FAIL bp_swap v=%b sel=%0d data=%h expected 1/3/c3", bus.out_valid, bus.out_sel, bus.out_data);
        end
        bus.in_valid = 8'h00;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_wrap_sparse();
        logic [2:0] exp_sel [4] = '{3'd7, 3'd1, 3'd7, 3'd1};
        do_reset();
        bus.in_valid = 8'h40;
        bus.in_last = 8'hFF;
        for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = 8'h70 + 8'(i);
        @(negedge clk);
        bus.in_valid = 8'h82;
        #1;
        checks++;
        if (bus.in_ready !== 8'h80) begin
            failures++;
            $display("FAIL wrap_first_grant in_ready=%h expected 80", bus.in_ready);
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, exp_sel[n], 8'h70 + 8'(exp_sel[n])}) begin
                failures++;
                $display("FAIL wrap_beat%0d sel=%0d data=%h expected sel=%0d", n, bus.out_sel, bus.out_data, exp_sel[n]);
            end
        end
        bus.in_valid = 8'h00;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL wrap_idle out_valid=%b expected 0", bus.out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.in_valid = 8'h10;
        bus.in_last = 8'h00;
        bus.in_data[4*8 +: 8] = 8'hD0;
        bus.in_data[0 +: 8] = 8'hE0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd4, 8'hD0}) begin
            failures++;
            $display("FAIL areset_pre sel=%0d data=%h expected 4/d0", bus.out_sel, bus.out_data);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last, bus.in_ready} !== 21'h0) begin
            failures++;
            $display("FAIL areset_clear v=%b sel=%0d data=%h last=%b in_ready=%h expected all 0", bus.out_valid, bus.out_sel, bus.out_data, bus.out_last, bus.in_ready);
        end
        #1 rst_n = 1'b1;
        bus.in_valid = 8'h11;
        bus.in_last = 8'hFF;
        #1;
        checks++;
        if (bus.in_ready !== 8'h01) begin
            failures++;
            $display("FAIL areset_unlocked in_ready=%h expected 01", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd0, 8'hE0}) begin
            failures++;
            $display("FAIL areset_next sel=%0d data=%h expected 0/e0", bus.out_sel, bus.out_data);
        end
        bus.in_valid = 8'h00;
    endtask

    initial begin
        bus.in_valid = 8'h00;
        bus.in_last = 8'hFF;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_wrap_sparse();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_8to1_rr.md
Name: mux_8to1_rr

Overview:
- Sequential 8-to-1 channel multiplexer with valid/ready handshakes.
- Merges eight independent input streams onto one output stream using round-robin arbitration.
- Multi-beat packets are locked to one channel until the packet's last beat is accepted.
- Each output beat carries a 3-bit channel index (out_sel), so a downstream 1-to-8 demultiplexer can steer the beat back to the matching channel.

Parameters:
- WIDTH, 8, data bits per beat.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  8  per-channel beat valid; bit i belongs to channel i.
- in_data  input  8*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
- in_last  input  8  per-channel end-of-packet flag; a single-beat packet has last=1.
- in_ready  output  8  per-channel accept; at most one bit high in any cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  beat data.
- out_sel  output  3  source channel index of the beat.
- out_last  output  1  end-of-packet flag of the beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset: asynchronous, active-low; clock and reset are as stated above.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - in_ready: all zero while rst_n=0.
- Transfers:
  - Input transfer on channel i: in_valid[i] && in_ready[i] at a clock edge.
  - Output transfer: out_valid && out_ready at a clock edge.
- Load enable: load_en = !out_valid || out_ready. The output register can be refilled in the same cycle it is drained, giving 1 beat/clk sustained throughput.
- Latency: an accepted beat appears on out_* on the next cycle (1 clk).
- Output stability: while out_valid=1 && out_ready=0, out_data, out_sel and out_last hold their values.
- in_ready is combinational: in_ready[i] = load_en && grant[i]. grant is one-hot or zero.
- State IDLE:
  - grant goes to the first channel c with in_valid[c]=1, searching c = ptr, ptr+1, ... modulo 8 (7 wraps to 0).
  - If no channel is valid, grant=0.
  - Accepted beat with last=1: stay IDLE; ptr <= (c+1) mod 8.
  - Accepted beat with last=0: go to LOCKED; lock_ch <= c.
- State LOCKED:
  - grant[lock_ch] = in_valid[lock_ch]; all other channels get grant=0, even if valid.
  - Locked channel deasserts valid: bubble; remain LOCKED; no other channel is served.
  - Accepted beat with last=1: go to IDLE; ptr <= (lock_ch+1) mod 8.
  - Accepted beat with last=0: remain LOCKED.
- Output register update:
  - Input transfer: out_valid<=1 and out_data/out_sel/out_last are loaded from the granted channel.
  - Output transfer with no input transfer: out_valid<=0; data fields keep their last values.
- Simultaneous output pop and input accept in one cycle: the new beat replaces the old one; out_valid stays 1; no beat is lost or duplicated.
- Starvation bound: in IDLE, a persistently valid single-beat channel is granted within 8 grants.
- Reset asserted mid-packet: lock and ptr are cleared immediately; the partially sent packet is abandoned, with no recovery beat.
- Upstream rule: in_valid/in_data/in_last must not depend combinationally on in_ready. Upstream must hold its beat until accepted.

Test Plan:
- Reset: hold rst_n=0 with in_valid=8'hFF -> in_ready=0, out_valid=0, out_sel=0; release; first accept is channel 0.
- Fairness: in_valid=8'hFF, in_last=8'hFF, out_ready=1 continuously -> out_sel sequence 0,1,2,...,7,0,1, one beat/clk, after 1-clk latency.
- Packet lock: ch2 sends 3 beats (last on the 3rd) while ch5 is valid -> out_sel = 2,2,2 with data in order, then 5; ch5 in_ready stays 0 during the lock; a bubble inserted on ch2 mid-packet keeps the lock.
- Backpressure: out_ready=0 for 4 clks with a beat held -> out_data/out_sel constant; all in_ready=0; on release, 1 beat/clk resumes with no loss and no duplication.
- Wrap and sparse: only ch7 and ch1 valid, ptr=7 -> grant order 7, 1, 7, 1; idle cycles give out_valid=0 after the final pop.
- Async reset mid-packet: ch4 beat 1 of 3 accepted, then rst_n pulse between edges -> outputs cleared immediately; next arbitration starts at ch0, ch4 not locked.
